// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multiply-accumulate unit.
// Operands are registered on En, then the product moves through MULT_LATENCY-1
// register stages and is added into the accumulator. The accumulator can wrap
// or saturate, and it drives a sticky overflow flag. Clr flushes the products
// that are still in flight. It does not drop an operand sampled on the same edge.
module mac_pipe #(
    parameter int DATA_WIDTH   = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int MULT_LATENCY = 2,
    parameter int SIGNED       = 0,
    parameter int SATURATE     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  En,
    input  logic                  Clr,
    input  logic [DATA_WIDTH-1:0] Ain,
    input  logic [DATA_WIDTH-1:0] Bin,
    output logic [ACC_WIDTH-1:0]  Cout,
    output logic                  Cout_vld,
    output logic                  Ovf,
    output logic                  Busy
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [PW-1:0]           a_ext, b_ext;
    logic [PW-1:0]           prod_c;
    logic [PW-1:0]           prod_last;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH:0]      sum;
    logic                    ovf_c;
    logic [ACC_WIDTH-1:0]    sat_val;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic [MULT_LATENCY-1:0] vld;
    logic                    acc_en;

    // Operand capture stage; data registers need no reset because the valid bits qualify them
    always_ff @(posedge clk) begin
        if (En) begin
            a_q <= Ain;
            b_q <= Bin;
        end
    end

    // Operands are widened first, so one unsigned multiply serves both modes.
    // The low PW bits of the product are the correct two's-complement result.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = PW'($signed(a_q));
            b_ext = PW'($signed(b_q));
        end else begin
            a_ext = PW'(a_q);
            b_ext = PW'(b_q);
        end
        prod_c = a_ext * b_ext;
    end

    generate
        if (MULT_LATENCY == 1) begin : g_no_pipe
            assign prod_last = prod_c;
        end else begin : g_pipe
            logic [PW-1:0] prod_q [1:MULT_LATENCY-1];

            // Product register chain between the operand stage and the accumulator
            always_ff @(posedge clk) begin
                prod_q[1] <= prod_c;
                for (int unsigned i = 2; i < MULT_LATENCY; i++) begin
                    prod_q[i] <= prod_q[i-1];
                end
            end

            assign prod_last = prod_q[MULT_LATENCY-1];
        end
    endgenerate

    // Extend the product to accumulator width, add it, and detect overflow
    always_comb begin
        if (SIGNED != 0) begin
            prod_ext = ACC_WIDTH'($signed(prod_last));
        end else begin
            prod_ext = ACC_WIDTH'(prod_last);
        end
        sum = {1'b0, Cout} + {1'b0, prod_ext};
        if (SIGNED != 0) begin
            ovf_c = (Cout[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != Cout[ACC_WIDTH-1]);
        end else begin
            ovf_c = sum[ACC_WIDTH];
        end
        if (SIGNED != 0) begin
            sat_val = '0;
            sat_val[ACC_WIDTH-1] = Cout[ACC_WIDTH-1];
            for (int unsigned i = 0; i < ACC_WIDTH - 1; i++) begin
                sat_val[i] = ~Cout[ACC_WIDTH-1];
            end
        end else begin
            sat_val = '1;
        end
        if ((SATURATE != 0) && ovf_c) begin
            acc_next = sat_val;
        end else begin
            acc_next = sum[ACC_WIDTH-1:0];
        end
    end

    assign acc_en = vld[MULT_LATENCY-1] & ~Clr;
    assign Busy   = |vld;

    // Valid shift register. Clr drops the in-flight stages but keeps the
    // operand sampled on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= En;
            for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
                vld[i] <= Clr ? 1'b0 : vld[i-1];
            end
        end
    end

    // Accumulator, update strobe and sticky overflow; Clr has priority over an update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Cout     <= '0;
            Cout_vld <= 1'b0;
            Ovf      <= 1'b0;
        end else if (Clr) begin
            Cout     <= '0;
            Cout_vld <= 1'b0;
            Ovf      <= 1'b0;
        end else begin
            Cout_vld <= acc_en;
            if (acc_en) begin
                Cout <= acc_next;
                if (ovf_c) begin
                    Ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: directed self-checking bench for mac_pipe across several parameter sets.
// All instances share the same inputs. Each test task checks only the instances it targets.
module tb_mac_pipe;

    logic       clk;
    logic       rst_n;
    logic       En;
    logic       Clr;
    logic [7:0] Ain;
    logic [7:0] Bin;

    logic [23:0] cout_def, cout_l1, cout_l3, cout_l4, cout_sgn;
    logic [15:0] cout_sat, cout_wrap, cout_ssat;
    logic vld_def, vld_l1, vld_l3, vld_l4, vld_sgn, vld_sat, vld_wrap, vld_ssat;
    logic ovf_def, ovf_l1, ovf_l3, ovf_l4, ovf_sgn, ovf_sat, ovf_wrap, ovf_ssat;
    logic busy_def, busy_l1, busy_l3, busy_l4, busy_sgn, busy_sat, busy_wrap, busy_ssat;

    int tests;
    int fails;

    mac_pipe u_def (.clk(clk), .rst_n(rst_n), .En(En), .Clr(Clr), .Ain(Ain), .Bin(Bin),
        .Cout(cout_def), .Cout_vld(vld_def), .Ovf(ovf_def), .Busy(busy_def));
    mac_pipe #(.MULT_LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .En(En), .Clr(Clr),
        .Ain(Ain), .Bin(Bin), .Cout(cout_l1), .Cout_vld(vld_l1), .Ovf(ovf_l1), .Busy(busy_l1));
    mac_pipe #(.MULT_LATENCY(3)) u_l3 (.clk(clk), .rst_n(rst_n), .En(En), .Clr(Clr),
        .Ain(Ain), .Bin(Bin), .Cout(cout_l3), .Cout_vld(vld_l3), .Ovf(ovf_l3), .Busy(busy_l3));
    mac_pipe #(.MULT_LATENCY(4)) u_l4 (.clk(clk), .rst_n(rst_n), .En(En), .Clr(Clr),
        .Ain(Ain), .Bin(Bin), .Cout(cout_l4), .Cout_vld(vld_l4), .Ovf(ovf_l4), .Busy(busy_l4));
    mac_pipe #(.SIGNED(1)) u_sgn (.clk(clk), .rst_n(rst_n), .En(En), .Clr(Clr),
        .Ain(Ain), .Bin(Bin), .Cout(cout_sgn), .Cout_vld(vld_sgn), .Ovf(ovf_sgn), .Busy(busy_sgn));
    mac_pipe #(.ACC_WIDTH(16), .SATURATE(1)) u_sat (.clk(clk), .rst_n(rst_n), .En(En),
        .Clr(Clr), .Ain(Ain), .Bin(Bin), .Cout(cout_sat), .Cout_vld(vld_sat), .Ovf(ovf_sat),
        .Busy(busy_sat));
    mac_pipe #(.ACC_WIDTH(16), .SATURATE(0)) u_wrap (.clk(clk), .rst_n(rst_n), .En(En),
        .Clr(Clr), .Ain(Ain), .Bin(Bin), .Cout(cout_wrap), .Cout_vld(vld_wrap), .Ovf(ovf_wrap),
        .Busy(busy_wrap));
    mac_pipe #(.ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) u_ssat (.clk(clk), .rst_n(rst_n),
        .En(En), .Clr(Clr), .Ain(Ain), .Bin(Bin), .Cout(cout_ssat), .Cout_vld(vld_ssat),
        .Ovf(ovf_ssat), .Busy(busy_ssat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        Clr = 1'b1;
        En  = 1'b0;
        tick();
        Clr = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (cout_def !== 24'd0 || vld_def !== 1'b0 || ovf_def !== 1'b0 || busy_def !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: cout=%0d vld=%b ovf=%b busy=%b, expected 0/0/0/0",
                     cout_def, vld_def, ovf_def, busy_def);
        end
    endtask

    task automatic test_unsigned_basic();
        logic [23:0] exp_c [0:5];
        logic        exp_v [0:5];
        logic        exp_b [0:5];
        exp_c = '{24'd0, 24'd0, 24'd12, 24'd42, 24'd65067, 24'd65067};
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_clear();
        for (int k = 0; k < 6; k++) begin
            En  = (k < 3);
            Ain = (k == 0) ? 8'd3 : (k == 1) ? 8'd5 : 8'd255;
            Bin = (k == 0) ? 8'd4 : (k == 1) ? 8'd6 : 8'd255;
            tick();
            tests++;
            if (cout_def !== exp_c[k] || vld_def !== exp_v[k] || busy_def !== exp_b[k]) begin
                fails++;
                $display("FAIL unsigned_basic edge %0d: cout=%0d vld=%b busy=%b, expected %0d/%b/%b",
                         k, cout_def, vld_def, busy_def, exp_c[k], exp_v[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_latency_sweep();
        logic [23:0] c [1:4];
        logic        v [1:4];
        do_clear();
        En = 1'b1; Ain = 8'd7; Bin = 8'd9;
        tick();
        En = 1'b0; Ain = 8'd0; Bin = 8'd0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            c[1] = cout_l1; c[2] = cout_def; c[3] = cout_l3; c[4] = cout_l4;
            v[1] = vld_l1;  v[2] = vld_def;  v[3] = vld_l3;  v[4] = vld_l4;
            for (int l = 1; l <= 4; l++) begin
                tests++;
                if (c[l] !== ((k >= l) ? 24'd63 : 24'd0) || v[l] !== (k == l)) begin
                    fails++;
                    $display("FAIL latency L=%0d edge+%0d: cout=%0d vld=%b, expected %0d/%b",
                             l, k, c[l], v[l], (k >= l) ? 63 : 0, (k == l));
                end
            end
        end
    endtask

    task automatic test_clear_flush();
        do_clear();
        En = 1'b1; Ain = 8'd10; Bin = 8'd10;
        tick();
        Ain = 8'd2; Bin = 8'd2;
        tick();
        Clr = 1'b1; Ain = 8'd1; Bin = 8'd1;
        tick();
        Clr = 1'b0; En = 1'b0;
        tests++;
        if (cout_l3 !== 24'd0 || ovf_l3 !== 1'b0) begin
            fails++;
            $display("FAIL clear_flush at clr edge: cout=%0d ovf=%b, expected 0/0", cout_l3, ovf_l3);
        end
        for (int k = 3; k <= 6; k++) begin
            tick();
            tests++;
            if (cout_l3 !== ((k >= 5) ? 24'd1 : 24'd0) || vld_l3 !== (k == 5)) begin
                fails++;
                $display("FAIL clear_flush edge t+%0d: cout=%0d vld=%b, expected %0d/%b",
                         k, cout_l3, vld_l3, (k >= 5) ? 1 : 0, (k == 5));
            end
        end
    endtask

    task automatic test_signed();
        do_clear();
        En = 1'b1; Ain = 8'hFD; Bin = 8'h05;
        tick();
        Ain = 8'h02; Bin = 8'hFC;
        tick();
        En = 1'b0;
        tick();
        tests++;
        if (cout_sgn !== 24'hFFFFF1 || ovf_sgn !== 1'b0) begin
            fails++;
            $display("FAIL signed_first: cout=%h ovf=%b, expected fffff1/0", cout_sgn, ovf_sgn);
        end
        tick();
        tests++;
        if (cout_sgn !== 24'hFFFFE9 || ovf_sgn !== 1'b0) begin
            fails++;
            $display("FAIL signed_second: cout=%h ovf=%b, expected ffffe9/0", cout_sgn, ovf_sgn);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        En = 1'b1; Ain = 8'd255; Bin = 8'd255;
        tick();
        tick();
        En = 1'b0;
        tick();
        tests++;
        if (cout_sat !== 16'd65025 || ovf_sat !== 1'b0 || cout_wrap !== 16'd65025 || ovf_wrap !== 1'b0) begin
            fails++;
            $display("FAIL sat_first: sat=%0d/%b wrap=%0d/%b, expected 65025/0 65025/0",
                     cout_sat, ovf_sat, cout_wrap, ovf_wrap);
        end
        tick();
        tests++;
        if (cout_sat !== 16'd65535 || ovf_sat !== 1'b1) begin
            fails++;
            $display("FAIL sat_clamp: cout=%0d ovf=%b, expected 65535/1", cout_sat, ovf_sat);
        end
        tests++;
        if (cout_wrap !== 16'd64514 || ovf_wrap !== 1'b1) begin
            fails++;
            $display("FAIL wrap_mode: cout=%0d ovf=%b, expected 64514/1", cout_wrap, ovf_wrap);
        end
    endtask

    task automatic test_signed_saturation();
        logic [15:0] exp_c [0:2];
        logic        exp_o [0:2];
        exp_c = '{16'hC080, 16'h8100, 16'h8000};
        exp_o = '{1'b0, 1'b0, 1'b1};
        do_clear();
        En = 1'b1; Ain = 8'h80; Bin = 8'h7F;
        tick();
        tick();
        tick();
        En = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            tests++;
            if (cout_ssat !== exp_c[k] || ovf_ssat !== exp_o[k]) begin
                fails++;
                $display("FAIL signed_sat step %0d: cout=%h ovf=%b, expected %h/%b",
                         k, cout_ssat, ovf_ssat, exp_c[k], exp_o[k]);
            end
        end
        do_clear();
        tests++;
        if (cout_ssat !== 16'd0 || ovf_ssat !== 1'b0) begin
            fails++;
            $display("FAIL clr_ovf: cout=%h ovf=%b, expected 0/0", cout_ssat, ovf_ssat);
        end
    endtask

    task automatic test_reset_midstream();
        do_clear();
        En = 1'b1; Ain = 8'd3; Bin = 8'd4;
        tick();
        tick();
        tick();
        tests++;
        if (cout_def !== 24'd12 || busy_def !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: cout=%0d busy=%b, expected 12/1", cout_def, busy_def);
        end
        #2;
        rst_n = 1'b0;
        En    = 1'b0;
        #1;
        tests++;
        if (cout_def !== 24'd0 || vld_def !== 1'b0 || ovf_def !== 1'b0 || busy_def !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: cout=%0d vld=%b ovf=%b busy=%b, expected 0/0/0/0",
                     cout_def, vld_def, ovf_def, busy_def);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (cout_def !== 24'd0 || vld_def !== 1'b0 || busy_def !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle %0d: cout=%0d vld=%b busy=%b, expected 0/0/0",
                         k, cout_def, vld_def, busy_def);
            end
        end
        En = 1'b1; Ain = 8'd1; Bin = 8'd1;
        tick();
        En = 1'b0;
        tick();
        tick();
        tests++;
        if (cout_def !== 24'd1 || vld_def !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_update: cout=%0d vld=%b, expected 1/1", cout_def, vld_def);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        En    = 1'b0;
        Clr   = 1'b0;
        Ain   = 8'd0;
        Bin   = 8'd0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_unsigned_basic();
        test_latency_sweep();
        test_clear_flush();
        test_signed();
        test_saturation();
        test_signed_saturation();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
